// File: rtl/spi_frame_shifter.sv
// SPI mode-0 frame shifter: assembles MSB-first receive frames and shifts a
// preloaded word out on miso, driven by pre-synchronized SCLK edge pulses.
`timescale 1ns/1ps

module spi_frame_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             mosi,
    input  logic             sclk_rise,
    input  logic             sclk_fall,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             frame_valid,
    output logic             frame_abort,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;

    assign miso = tx_shift[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (tx_load) begin
                        tx_shift <= tx_data;
                    end
                    if (!cs_n) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    // A load only lands between frames; it beats a same-cycle fall.
                    if (tx_load && (bit_cnt == '0)) begin
                        tx_shift <= tx_data;
                    end else if (sclk_fall && (bit_cnt != '0) && !cs_n) begin
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                    end

                    // Deselect wins over any simultaneous rising-edge sample.
                    if (cs_n) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        if (bit_cnt != '0) begin
                            frame_abort <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b1;
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[WIDTH-2:0], mosi};
                            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                                rx_data     <= {rx_shift[WIDTH-2:0], mosi};
                                frame_valid <= 1'b1;
                                bit_cnt     <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_shifter.sv
// Directed bench for spi_frame_shifter with hand-computed expected values.
`timescale 1ns/1ps

module tb_spi_frame_shifter;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic       mosi;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       miso;
    logic [7:0] rx_data;
    logic       frame_valid;
    logic       frame_abort;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    spi_frame_shifter #(.WIDTH(8), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .sclk_rise   (sclk_rise),
        .sclk_fall   (sclk_fall),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .miso        (miso),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_abort (frame_abort),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise(input logic b);
        mosi      = b;
        sclk_rise = 1'b1;
        tick();
        sclk_rise = 1'b0;
    endtask

    task automatic fall();
        sclk_fall = 1'b1;
        tick();
        sclk_fall = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] val, input string tag);
        logic [7:0] v;
        v = val;
        for (int i = 7; i >= 0; i--) begin
            rise(v[i]);
            if (i != 0) check({tag, "_fv_low"}, 32'(frame_valid), 32'd0);
        end
        check({tag, "_fv"}, 32'(frame_valid), 32'd1);
        check({tag, "_rx"}, 32'(rx_data), 32'(val));
        tick();
        check({tag, "_fv_pulse"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Idle with cs_n high: rising pulses must be ignored.
        for (int k = 0; k < 3; k++) begin
            rise(1'b1);
            check("idle_fv", 32'(frame_valid), 32'd0);
            check("idle_abort", 32'(frame_abort), 32'd0);
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_rx", 32'(rx_data), 32'h00);
        check("idle_miso", 32'(miso), 32'd0);

        // Single receive frame.
        cs_n = 1'b0;
        tick();
        check("start_busy", 32'(busy), 32'd1);
        send_byte(8'hA5, "a5");
        cs_n = 1'b1;
        tick();
        check("a5_end_busy", 32'(busy), 32'd0);
        check("a5_end_abort", 32'(frame_abort), 32'd0);

        // Transmit 3C, sampling miso before every rising pulse.
        pat = 8'h3C;
        tx_data = 8'h3C; tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        cs_n = 1'b0;
        tick();
        for (int i = 7; i >= 0; i--) begin
            check("tx3c_miso", 32'(miso), 32'(pat[i]));
            rise(1'b0);
            fall();
        end
        cs_n = 1'b1;
        tick();

        // Back-to-back frames.
        cs_n = 1'b0;
        tick();
        send_byte(8'hFF, "ff");
        send_byte(8'h01, "b2b_01");
        check("b2b_busy", 32'(busy), 32'd1);
        cs_n = 1'b1;
        tick();

        // Abort after 3 bits.
        cs_n = 1'b0;
        tick();
        rise(1'b1); rise(1'b1); rise(1'b0);
        cs_n = 1'b1;
        tick();
        check("abort_strobe", 32'(frame_abort), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rx", 32'(rx_data), 32'h01);
        check("abort_fv", 32'(frame_valid), 32'd0);
        tick();
        check("abort_pulse", 32'(frame_abort), 32'd0);

        // Load mid-frame ignored; deselect on the final rising edge aborts.
        pat = 8'hC3;
        tx_data = 8'hC3; tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        cs_n = 1'b0;
        tick();
        for (int i = 7; i >= 4; i--) begin
            check("c3_miso", 32'(miso), 32'(pat[i]));
            rise(1'b1);
            fall();
        end
        tx_data = 8'h81; tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            check("c3_noload_miso", 32'(miso), 32'(pat[i]));
            rise(1'b1);
            fall();
        end
        check("c3_last_miso", 32'(miso), 32'(pat[0]));
        cs_n = 1'b1;
        rise(1'b1);
        check("race_fv", 32'(frame_valid), 32'd0);
        check("race_abort", 32'(frame_abort), 32'd1);
        check("race_busy", 32'(busy), 32'd0);
        check("race_rx", 32'(rx_data), 32'h01);
        tick();

        // Asynchronous reset mid-frame.
        tx_data = 8'hFF; tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        cs_n = 1'b0;
        tick();
        rise(1'b1); rise(1'b0); rise(1'b1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_miso", 32'(miso), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx", 32'(rx_data), 32'h00);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_abort", 32'(frame_abort), 32'd0);
        cs_n = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_abort", 32'(frame_abort), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
